// File: rtl/tick_debounce_repeat.sv
//------------------------------------------------------------------------------
// Module   : tick_debounce_repeat
// Purpose  : Tick-paced debouncer for one push-button with press/release and
//            auto-repeat strobes.
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tick_debounce_repeat #(
  parameter int DEBOUNCE_TICKS = 4,
  parameter int HOLD_TICKS     = 50,
  parameter int REPEAT_TICKS   = 10,
  parameter int CNT_W          = 8
) (
  input  logic clk,
  input  logic rst,
  input  logic i_tick,
  input  logic i_btn_raw,
  output logic o_level,
  output logic o_press,
  output logic o_release,
  output logic o_rpt
);

  localparam logic [CNT_W-1:0] c_one          = CNT_W'(1);
  localparam logic [CNT_W-1:0] c_zero         = '0;
  localparam logic [CNT_W-1:0] c_deb_ticks    = CNT_W'(DEBOUNCE_TICKS);
  localparam logic [CNT_W-1:0] c_hold_ticks   = CNT_W'(HOLD_TICKS);
  localparam logic [CNT_W-1:0] c_repeat_ticks = CNT_W'(REPEAT_TICKS);
  localparam bit               c_rpt_enabled  = (HOLD_TICKS != 0);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_HOLD     = 2'd1,
    S_REPEAT   = 2'd2,
    S_ARMED_NR = 2'd3
  } state_t;

  logic             r_sync_q1;
  logic             r_sync_q2;
  logic [CNT_W-1:0] r_db_cnt;
  logic             r_level;
  logic             r_press;
  logic             r_release;
  logic             r_rpt;
  logic [CNT_W-1:0] r_hr_cnt;
  state_t           r_state;

  logic             w_disagree;
  logic [CNT_W-1:0] w_db_cnt_inc;
  logic             w_db_done;
  logic             w_rise;
  logic             w_fall;
  logic [CNT_W-1:0] w_hr_cnt_inc;

  // Two-flop synchroniser; r_sync_q2 is the only copy of the button the logic sees.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync_q1 <= 1'b0;
      r_sync_q2 <= 1'b0;
    end else begin
      r_sync_q1 <= i_btn_raw;
      r_sync_q2 <= r_sync_q1;
    end
  end

  assign w_disagree   = (r_sync_q2 != r_level);
  assign w_db_cnt_inc = r_db_cnt + c_one;
  assign w_db_done    = i_tick && w_disagree && (w_db_cnt_inc == c_deb_ticks);
  assign w_rise       = w_db_done && !r_level;
  assign w_fall       = w_db_done &&  r_level;
  assign w_hr_cnt_inc = r_hr_cnt + c_one;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_db_cnt  <= c_zero;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= w_rise;
      r_release <= w_fall;
      if (i_tick) begin
        if (!w_disagree) begin
          r_db_cnt <= c_zero;
        end else if (w_db_done) begin
          r_level  <= r_sync_q2;
          r_db_cnt <= c_zero;
        end else begin
          r_db_cnt <= w_db_cnt_inc;
        end
      end
    end
  end

  // A falling level pre-empts a repeat due on the same tick.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_hr_cnt <= c_zero;
      r_rpt    <= 1'b0;
    end else begin
      r_rpt <= 1'b0;
      if (w_fall) begin
        r_state  <= S_IDLE;
        r_hr_cnt <= c_zero;
      end else begin
        case (r_state)
          S_IDLE: begin
            if (w_rise) begin
              r_hr_cnt <= c_zero;
              r_state  <= c_rpt_enabled ? S_HOLD : S_ARMED_NR;
            end
          end
          S_HOLD: begin
            if (i_tick) begin
              if (w_hr_cnt_inc == c_hold_ticks) begin
                r_rpt    <= 1'b1;
                r_hr_cnt <= c_zero;
                r_state  <= S_REPEAT;
              end else begin
                r_hr_cnt <= w_hr_cnt_inc;
              end
            end
          end
          S_REPEAT: begin
            if (i_tick) begin
              if (w_hr_cnt_inc == c_repeat_ticks) begin
                r_rpt    <= 1'b1;
                r_hr_cnt <= c_zero;
              end else begin
                r_hr_cnt <= w_hr_cnt_inc;
              end
            end
          end
          S_ARMED_NR: begin
            r_hr_cnt <= c_zero;
          end
          default: begin
            r_state  <= S_IDLE;
            r_hr_cnt <= c_zero;
          end
        endcase
      end
    end
  end

  assign o_level   = r_level;
  assign o_press   = r_press;
  assign o_release = r_release;
  assign o_rpt     = r_rpt;

endmodule

`default_nettype wire

// File: tb/tb_tick_debounce_repeat.sv
//------------------------------------------------------------------------------
// Module   : tb_tick_debounce_repeat
// Purpose  : Directed scoreboard bench for tick_debounce_repeat (repeat and
//            no-repeat builds driven side by side).
// Revision : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_tick_debounce_repeat;

  logic clk = 1'b0;
  logic rst;
  logic tick;
  logic btn;
  logic a_level, a_press, a_release, a_rpt;
  logic n_level, n_press, n_release, n_rpt;

  int n_checks = 0;
  int n_fail = 0;
  int tick_idx = 0;
  int cyc = 0;
  int rpt_seen_a = 0;
  bit cont = 1'b0;

  // Event code = kind*100000 + tick index; kind 1=press, 2=release, 3=rpt.
  int exp_q[$];
  int exp_nr_q[$];

  tick_debounce_repeat #(
    .DEBOUNCE_TICKS(4), .HOLD_TICKS(5), .REPEAT_TICKS(3), .CNT_W(8)
  ) dut (
    .clk(clk), .rst(rst), .i_tick(tick), .i_btn_raw(btn),
    .o_level(a_level), .o_press(a_press), .o_release(a_release), .o_rpt(a_rpt)
  );

  tick_debounce_repeat #(
    .DEBOUNCE_TICKS(4), .HOLD_TICKS(0), .REPEAT_TICKS(3), .CNT_W(8)
  ) dut_nr (
    .clk(clk), .rst(rst), .i_tick(tick), .i_btn_raw(btn),
    .o_level(n_level), .o_press(n_press), .o_release(n_release), .o_rpt(n_rpt)
  );

  always #5 clk = ~clk;

  initial begin
    tick = 1'b0;
    forever begin
      @(negedge clk);
      cyc++;
      tick = cont || (cyc % 10 == 0);
    end
  end

  always @(posedge clk) if (tick) tick_idx++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_checks++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
    end
  endtask

  task automatic observe(input int which, input int kind);
    int act_code;
    int exp_code;
    act_code = kind * 100000 + tick_idx;
    exp_code = -1;
    if (which == 0 && exp_q.size() > 0) exp_code = exp_q.pop_front();
    if (which == 1 && exp_nr_q.size() > 0) exp_code = exp_nr_q.pop_front();
    n_checks++;
    assert (act_code === exp_code) else begin
      n_fail++;
      $error("FAIL event dut%0d: observed code %0d expected code %0d", which, act_code, exp_code);
    end
  endtask

  always @(negedge clk) begin
    if (a_press)   observe(0, 1);
    if (a_release) observe(0, 2);
    if (a_rpt) begin
      rpt_seen_a++;
      observe(0, 3);
    end
    if (n_press)   observe(1, 1);
    if (n_release) observe(1, 2);
    if (n_rpt)     observe(1, 3);
  end

  task automatic wait_ticks(input int n);
    for (int i = 0; i < n; i++) begin
      do @(posedge clk); while (tick !== 1'b1);
    end
    @(negedge clk);
  endtask

  // Press at tick p, level falls at tick f; repeats fire at p+5, p+8, ... strictly before f.
  task automatic push_hold_events(input int p, input int f, input bit with_rel);
    exp_q.push_back(100000 + p);
    exp_nr_q.push_back(100000 + p);
    for (int r = p + 5; r < f; r += 3) exp_q.push_back(300000 + r);
    if (with_rel) begin
      exp_q.push_back(200000 + f);
      exp_nr_q.push_back(200000 + f);
    end
  endtask

  task automatic finish_checks(input string tag, input int exp_rpts);
    check({tag, " level after release"}, a_level, 1'b0);
    check({tag, " nr level after release"}, n_level, 1'b0);
    check({tag, " rpt count"}, rpt_seen_a, exp_rpts);
    check({tag, " events left"}, exp_q.size(), 0);
    check({tag, " nr events left"}, exp_nr_q.size(), 0);
  endtask

  task automatic press_hold(input int hold, input int lat, input int exp_rpts, input string tag);
    int t;
    t = tick_idx;
    rpt_seen_a = 0;
    btn = 1'b1;
    push_hold_events(t + lat, t + hold + lat, 1'b1);
    wait_ticks(hold);
    check({tag, " level held"}, a_level, 1'b1);
    check({tag, " nr level held"}, n_level, 1'b1);
    btn = 1'b0;
    wait_ticks(lat + 2);
    finish_checks(tag, exp_rpts);
  endtask

  initial begin
    int t;
    int r_tick;
    int p2;
    rst = 1'b1;
    btn = 1'b0;
    repeat (3) @(negedge clk);
    check("reset level", a_level, 1'b0);
    check("reset press", a_press, 1'b0);
    check("reset release", a_release, 1'b0);
    check("reset rpt", a_rpt, 1'b0);
    rst = 1'b0;
    wait_ticks(2);

    // Short glitch between ticks must be ignored.
    repeat (2) @(negedge clk);
    btn = 1'b1;
    repeat (3) @(negedge clk);
    btn = 1'b0;
    wait_ticks(3);
    check("glitch level", a_level, 1'b0);
    check("glitch events", exp_q.size(), 0);

    press_hold(30, 4, 9, "hold30");
    press_hold(35, 4, 10, "fall_on_rpt");

    btn = 1'b1; wait_ticks(1);
    btn = 1'b0; wait_ticks(1);
    btn = 1'b1; wait_ticks(1);
    btn = 1'b0; wait_ticks(1);
    press_hold(8, 4, 1, "bounce");

    cont = 1'b1;
    wait_ticks(4);
    press_hold(12, 6, 3, "cont_tick");
    cont = 1'b0;
    wait_ticks(3);

    // Reset while in REPEAT, button kept held across it.
    t = tick_idx;
    rpt_seen_a = 0;
    btn = 1'b1;
    r_tick = t + 13;
    push_hold_events(t + 4, r_tick + 1, 1'b0);
    wait_ticks(13);
    check("pre-reset level", a_level, 1'b1);
    #2 rst = 1'b1;
    #1;
    check("async reset level", a_level, 1'b0);
    check("async reset rpt", a_rpt, 1'b0);
    check("async reset press", a_press, 1'b0);
    check("async reset nr level", n_level, 1'b0);
    check("pre-reset rpt count", rpt_seen_a, 2);
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    rpt_seen_a = 0;
    p2 = r_tick + 4;
    push_hold_events(p2, p2 + 14, 1'b1);
    wait_ticks(14);
    check("post-reset level held", a_level, 1'b1);
    btn = 1'b0;
    wait_ticks(6);
    finish_checks("post_reset", 3);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: observed timeout expected completion");
    $fatal(1, "timeout");
  end

endmodule

`default_nettype wire
